// File: rtl/approx_mult_seq.sv
// ---------------------------------------------------------------------------
// approx_mult_seq
//
// Sequential approximate multiplier for unsigned N-bit operands.
//
// How the approximate path works:
//   - Each operand is normalised by shifting it left one bit per cycle until
//     its MSB is 1.
//   - The top K bits of each normalised operand are multiplied.
//   - The product is rescaled to 2N bits using the leading-one positions.
//
// Exact mode skips normalisation and forms the full N x N product. A zero
// operand in approximate mode takes an early-out straight to DONE.
//
// Ports:
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   start_i    : request; accepted only in IDLE
//   exact_i    : 1 = full product, 0 = approximate (sampled with start_i)
//   a_i, b_i   : N-bit unsigned operands (sampled with start_i)
//   busy_o     : high in every state except IDLE
//   valid_o    : one-cycle pulse; product_o and inexact_o are final then
//   product_o  : 2N-bit result; held until the next accepted start
//   inexact_o  : a nonzero operand bit was dropped by truncation
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module approx_mult_seq #(
  parameter int N = 16,
  parameter int K = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           exact_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           busy_o,
  output logic           valid_o,
  output logic [2*N-1:0] product_o,
  output logic           inexact_o
);

  localparam int SW = $clog2(N);
  localparam int TW = $clog2(2*N) + 1;

  // Weight of the product of two K-bit mantissas whose MSBs sit at bit K-1.
  localparam logic [TW-1:0] BIAS = TW'(2*(K-1));
  localparam logic [TW-1:0] EMAX = TW'(2*(N-1));

  // Ones in the N-K low bits that truncation discards (all zero when K = N).
  localparam logic [N-1:0] LOW_MASK = {N{1'b1}} >> K;

  typedef enum logic [1:0] {IDLE, NORM, MULT, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [SW-1:0]  sa_q, sa_d, sb_q, sb_d;
  logic           exact_q, exact_d;
  logic [2*N-1:0] product_q, product_d;
  logic           inexact_q, inexact_d;

  // Approximate datapath, evaluated on the normalised operand registers.
  logic [K-1:0]   ma, mb;
  logic [2*N-1:0] p_wide, prod_approx, prod_exact;
  logic [TW-1:0]  t_exp;

  assign ma     = a_q[N-1 -: K];
  assign mb     = b_q[N-1 -: K];
  assign p_wide = (2*N)'(ma) * (2*N)'(mb);
  // eA + eB, where eX = N-1-sX.
  assign t_exp  = EMAX - TW'(sa_q) - TW'(sb_q);
  // The right shift only drops zero bits; the left shift never exceeds 2N.
  assign prod_approx = (t_exp >= BIAS) ? (p_wide << (t_exp - BIAS))
                                       : (p_wide >> (BIAS - t_exp));
  assign prod_exact  = (2*N)'(a_q) * (2*N)'(b_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      exact_q   <= 1'b0;
      product_q <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      exact_q   <= exact_d;
      product_q <= product_d;
      inexact_q <= inexact_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its hold value first, so no
    // path through the case statement can infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    exact_d   = exact_q;
    product_d = product_q;
    inexact_d = inexact_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          exact_d = exact_i;
          sa_d    = '0;
          sb_d    = '0;
          if (exact_i) begin
            state_d = MULT;
          end else if (a_i == '0 || b_i == '0) begin
            product_d = '0;
            inexact_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        // The cycle that sees both MSBs set does not shift.
        if (a_q[N-1] && b_q[N-1]) begin
          state_d = MULT;
        end else begin
          if (!a_q[N-1]) begin
            a_d  = a_q << 1;
            sa_d = sa_q + 1'b1;
          end
          if (!b_q[N-1]) begin
            b_d  = b_q << 1;
            sb_d = sb_q + 1'b1;
          end
        end
      end

      MULT: begin
        if (exact_q) begin
          product_d = prod_exact;
          inexact_d = 1'b0;
        end else begin
          product_d = prod_approx;
          inexact_d = |((a_q | b_q) & LOW_MASK);
        end
        state_d = MULT == MULT ? DONE : DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q != IDLE);
  assign valid_o   = (state_q == DONE);
  assign product_o = product_q;
  assign inexact_o = inexact_q;

endmodule

// File: tb/tb_approx_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_approx_mult_seq
//
// Self-checking bench for approx_mult_seq (N = 16, K = 8).
//
// Expected results come from a reference model written from the
// arithmetic definition of the multiplier:
//   - locate the leading one of each operand;
//   - normalise the operand and truncate it to K bits;
//   - multiply the mantissas and scale by a power of two.
//
// Directed scenarios also compare against literal expected values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_approx_mult_seq;

  localparam int N = 16;
  localparam int K = 8;
  localparam int BUDGET = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           exact_i;
  logic [N-1:0]   a_i;
  logic [N-1:0]   b_i;
  logic           busy_o;
  logic           valid_o;
  logic [2*N-1:0] product_o;
  logic           inexact_o;

  int n_vec = 0;
  int n_err = 0;

  approx_mult_seq #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .exact_i   (exact_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .product_o (product_o),
    .inexact_o (inexact_o)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the expected product, inexact flag and latency.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic ex, output logic [2*N-1:0] p,
                                output logic inx, output int lat);
    int ea, eb, sa, sb, e;
    longint unsigned na, nb, ma, mb, full, mask;
    if (ex) begin
      full = longint'(a) * longint'(b);
      p    = (2*N)'(full);
      inx  = 1'b0;
      lat  = 2;
    end else if (a == 0 || b == 0) begin
      p   = '0;
      inx = 1'b0;
      lat = 1;
    end else begin
      ea = -1;
      eb = -1;
      for (int i = 0; i < N; i++) begin
        if (a[i]) ea = i;
        if (b[i]) eb = i;
      end
      sa   = N - 1 - ea;
      sb   = N - 1 - eb;
      na   = longint'(a) << sa;
      nb   = longint'(b) << sb;
      ma   = na >> (N - K);
      mb   = nb >> (N - K);
      mask = (64'd1 << (N - K)) - 64'd1;
      e    = ea + eb - 2*(K-1);
      full = ma * mb;
      p    = (e >= 0) ? (2*N)'(full << e) : (2*N)'(full >> (-e));
      inx  = ((na | nb) & mask) != 0;
      lat  = ((sa > sb) ? sa : sb) + 3;
    end
  endfunction

  // Issue one job and observe it until the block returns to IDLE.
  // - If pulse_at >= 0, a second start (alt operands, exact=1) is held
  //   high during cycle c0+pulse_at.
  // - lat is -1 if no valid pulse arrives within the budget.
  task automatic run_job(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic ex, input int pulse_at,
                         output int lat, output logic [2*N-1:0] prod,
                         output logic inx, output int pulses,
                         output logic busy_ok);
    lat     = -1;
    prod    = '0;
    inx     = 1'b0;
    pulses  = 0;
    busy_ok = 1'b1;
    start_i = 1'b1;
    exact_i = ex;
    a_i     = a;
    b_i     = b;
    tick();                       // edge ending c0
    start_i = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (cyc > 1) tick();
      if (valid_o) begin
        pulses++;
        if (lat < 0) begin
          lat  = cyc;
          prod = product_o;
          inx  = inexact_o;
        end
      end
      if (lat < 0 && !busy_o) busy_ok = 1'b0;
      if (cyc == pulse_at) begin
        start_i = 1'b1;
        exact_i = 1'b1;
        a_i     = 16'hFFFF;
        b_i     = 16'h7777;
      end else if (cyc == pulse_at + 1) begin
        start_i = 1'b0;
      end
      if (lat >= 0 && !busy_o) break;
    end
    start_i = 1'b0;
  endtask

  // Compare one finished job against expected values.
  task automatic check_job(input string name, input int lat, input int exp_lat,
                           input logic [2*N-1:0] prod,
                           input logic [2*N-1:0] exp_prod,
                           input logic inx, input logic exp_inx,
                           input int pulses, input logic busy_ok);
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (prod !== exp_prod) begin
      n_err++;
      $display("FAIL %s product: got %h want %h", name, prod, exp_prod);
    end
    n_vec++;
    if (inx !== exp_inx) begin
      n_err++;
      $display("FAIL %s inexact: got %b want %b", name, inx, exp_inx);
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL %s valid pulses: got %0d want 1", name, pulses);
    end
    n_vec++;
    if (!busy_ok) begin
      n_err++;
      $display("FAIL %s busy dropped before valid: got 0 want 1", name);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start_i = 1'b0;
    exact_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    tick();
    tick();
    n_vec++;
    if ({busy_o, valid_o, inexact_o, product_o} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got busy=%b valid=%b inexact=%b product=%h want all 0",
               busy_o, valid_o, inexact_o, product_o);
    end
    rst = 1'b0;
    tick();
  endtask

  // Test-plan vectors with literal expected values.
  task automatic test_directed();
    int lat, pulses;
    logic [2*N-1:0] prod;
    logic inx, bok;
    run_job(16'h00F0, 16'h0003, 1'b0, -1, lat, prod, inx, pulses, bok);
    check_job("dir_00F0x0003", lat, 17, prod, 32'h000002D0, inx, 1'b0, pulses, bok);
    run_job(16'h1234, 16'h0100, 1'b0, -1, lat, prod, inx, pulses, bok);
    check_job("dir_1234x0100", lat, 10, prod, 32'h00122000, inx, 1'b1, pulses, bok);
    run_job(16'hFFFF, 16'hFFFF, 1'b0, -1, lat, prod, inx, pulses, bok);
    check_job("dir_FFFF_approx", lat, 3, prod, 32'hFE010000, inx, 1'b1, pulses, bok);
    run_job(16'hFFFF, 16'hFFFF, 1'b1, -1, lat, prod, inx, pulses, bok);
    check_job("dir_FFFF_exact", lat, 2, prod, 32'hFFFE0001, inx, 1'b0, pulses, bok);
  endtask

  // Zero early-out, then the maximum-latency case (one operand = 1).
  task automatic test_zero_and_max();
    int lat, pulses;
    logic [2*N-1:0] prod;
    logic inx, bok;
    run_job(16'h0000, 16'h5555, 1'b0, -1, lat, prod, inx, pulses, bok);
    check_job("zero_early_out", lat, 1, prod, 32'h0, inx, 1'b0, pulses, bok);
    run_job(16'h8000, 16'h0001, 1'b0, -1, lat, prod, inx, pulses, bok);
    check_job("max_latency", lat, N + 2, prod, 32'h00008000, inx, 1'b0, pulses, bok);
  endtask

  // Start pulses while busy (NORM) and in DONE must be ignored.
  // The product must then hold while idle.
  task automatic test_ignore_start();
    int lat, pulses;
    logic [2*N-1:0] prod;
    logic inx, bok;
    run_job(16'h00F0, 16'h0003, 1'b0, 3, lat, prod, inx, pulses, bok);
    check_job("start_in_norm", lat, 17, prod, 32'h000002D0, inx, 1'b0, pulses, bok);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (product_o !== 32'h000002D0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL hold_after_valid cycle %0d: got product=%h busy=%b valid=%b want 000002d0/0/0",
                 i, product_o, busy_o, valid_o);
      end
    end
    run_job(16'h0003, 16'h0005, 1'b1, 2, lat, prod, inx, pulses, bok);
    check_job("start_in_done", lat, 2, prod, 32'h0000000F, inx, 1'b0, pulses, bok);
    tick();
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done busy after: got %b want 0", busy_o);
    end
  endtask

  // Reset in NORM aborts the job; a start two cycles later works normally.
  task automatic test_reset_abort();
    int lat, pulses, seen;
    logic [2*N-1:0] prod;
    logic inx, bok;
    start_i = 1'b1;
    exact_i = 1'b0;
    a_i     = 16'h0001;
    b_i     = 16'h0003;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || product_o !== '0) begin
      n_err++;
      $display("FAIL reset_abort state: got busy=%b valid=%b product=%h want 0/0/0",
               busy_o, valid_o, product_o);
    end
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (valid_o || busy_o) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_abort activity after reset: got %0d cycles want 0", seen);
    end
    run_job(16'h1234, 16'h0100, 1'b0, -1, lat, prod, inx, pulses, bok);
    check_job("after_reset_abort", lat, 10, prod, 32'h00122000, inx, 1'b1, pulses, bok);
  endtask

  // Random jobs, each started in the cycle right after the previous DONE.
  task automatic test_back_to_back();
    int lat, pulses, exp_lat;
    logic [2*N-1:0] prod, exp_prod;
    logic inx, exp_inx, bok, ex;
    logic [N-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a  = N'($urandom) >> $urandom_range(0, N - 1);
      b  = N'($urandom) >> $urandom_range(0, N - 1);
      if ($urandom_range(0, 11) == 0) a = '0;
      if ($urandom_range(0, 11) == 0) b = '0;
      ex = ($urandom_range(0, 3) == 0);
      model(a, b, ex, exp_prod, exp_inx, exp_lat);
      run_job(a, b, ex, -1, lat, prod, inx, pulses, bok);
      check_job($sformatf("rand%0d_%h_%h_%b", i, a, b, ex), lat, exp_lat,
                prod, exp_prod, inx, exp_inx, pulses, bok);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_and_max();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
